// File: rtl/spi_controller_if.sv
// Request handshake and SPI pin bundle for spi_controller.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       done;
  logic       busy;
  logic       err;
  logic       sclk;
  logic       ncs;
  logic       copi;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, done, busy, err, sclk, ncs, copi
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, done, busy, err, sclk, ncs, copi
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: one 16-bit {1, addr, data} frame per request, MSB first.
// Optional address range check enabled by defining SPI_CONTROLLER_ADDR_CHECK_EN.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_GAP   = 4,
  parameter int MAX_ADDR = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_controller_if.slave bus
);
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_REJ   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic          sclk_q, sclk_d, ncs_q, ncs_d, copi_q, copi_d;
  logic          rdy_q, rdy_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          tick, addr_ok;

  assign tick    = (cnt_q == '0);
  assign addr_ok = !ADDR_CHECK || (int'(bus.req_addr) <= MAX_ADDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req_valid && rdy_q) begin
        rdy_d  = 1'b0;
        busy_d = 1'b1;
        if (addr_ok) begin
          sh_d    = {1'b1, bus.req_addr, bus.req_data};
          ncs_d   = 1'b0;
          copi_d  = 1'b1;
          cnt_d   = HALF_LD;
          state_d = S_SETUP;
        end else begin
          err_d   = 1'b1;
          state_d = S_REJ;
        end
      end
      S_REJ: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
      S_SETUP: if (tick) begin
        sclk_d  = 1'b1;
        bit_d   = 5'd1;
        cnt_d   = HALF_LD;
        state_d = S_SHIFT;
      end
      S_SHIFT: if (tick) begin
        cnt_d = HALF_LD;
        if (sclk_q) begin
          sclk_d = 1'b0;
          sh_d   = {sh_q[14:0], 1'b0};
          copi_d = (bit_q == 5'd16) ? 1'b0 : sh_q[14];
        end else if (bit_q == 5'd16) begin
          // last low half-period doubles as the nCS hold time
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          sclk_d = 1'b1;
          bit_d  = bit_q + 5'd1;
        end
      end
      S_GAP: if (tick) begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sclk      = sclk_q;
  assign bus.ncs       = ncs_q;
  assign bus.copi      = copi_q;
endmodule
